muldiv_wb_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit that sits directly upstream of the dual-write-port register file.
- Accepts one operation, iterates one bit per cycle, then issues a single write-back cycle.
- The write-back drives both register-file write ports on the same clock edge: port 1 carries the HI result, port 2 carries the LO result.
- Replaces a single-cycle combinational multiplier/divider in the execute path.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_sign_fix.sv | 12 +
 rtl/muldiv_wb_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_wb_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide write-back unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  function automatic logic isDivOp(input logic [1:0] o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic isSignedOp(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional negate: takes magnitudes on the way in, restores signs on the way out.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_wb_unit.sv
// Iterative mul/div, one bit per cycle, write-back of HI/LO on both regfile ports in one cycle (XLEN+2 cycles).
// No queueing: start is ignored while busy. MULDIV_EARLY_OUT_EN lets multiplies finish once the multiplier runs out.
module muldiv_wb_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [AW-1:0]   hiAddr,
  input  logic [AW-1:0]   loAddr,
  output logic            busy,
  output logic            done,
  output logic            divZero,
  output logic            writeEnable1,
  output logic [AW-1:0]   writeAddress1,
  output logic [XLEN-1:0] writeData1,
  output logic            writeEnable2,
  output logic [AW-1:0]   writeAddress2,
  output logic [XLEN-1:0] writeData2
);

  localparam int CW = $clog2(XLEN);

  state_t              state;
  logic [1:0]          opReg;
  logic [AW-1:0]       hiAddrReg, loAddrReg;
  logic [2*XLEN-1:0]   accReg;    // product accumulator; low half holds the remainder for divides
  logic [2*XLEN-1:0]   shiftReg;  // shifting multiplicand, or dividend morphing into the quotient
  logic [XLEN-1:0]     opBReg;    // shifting multiplier, or divisor
  logic [CW-1:0]       cnt;
  logic                negRes, negRem;

  logic [XLEN-1:0]     absA, absB;
  logic                inSigned;

  assign inSigned = isSignedOp(op);

  muldiv_sign_fix #(.W(XLEN)) uAbsA (.val(opA), .neg(inSigned & opA[XLEN-1]), .res(absA));
  muldiv_sign_fix #(.W(XLEN)) uAbsB (.val(opB), .neg(inSigned & opB[XLEN-1]), .res(absB));

  // One restoring-division step.
  logic [XLEN:0]       divShift, divDiff;
  logic                qBit;
  logic [XLEN-1:0]     remNext;
  logic [2*XLEN-1:0]   accMul;
  logic                lastIter;

  always_comb begin
    divShift = {accReg[XLEN-1:0], shiftReg[XLEN-1]};
    divDiff  = divShift - {1'b0, opBReg};
    qBit     = ~divDiff[XLEN];
    remNext  = qBit ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
    accMul   = accReg + (opBReg[0] ? shiftReg : '0);
`ifdef MULDIV_EARLY_OUT_EN
    lastIter = (cnt == '0) || (!isDivOp(opReg) && ((opBReg >> 1) == '0));
`else
    lastIter = (cnt == '0);
`endif
  end

  logic [2*XLEN-1:0]   prodFix;
  logic [XLEN-1:0]     quoFix, remFix, hiData, loData;

  muldiv_sign_fix #(.W(2*XLEN)) uFixProd (.val(accReg), .neg(negRes), .res(prodFix));
  muldiv_sign_fix #(.W(XLEN)) uFixQuo (.val(shiftReg[XLEN-1:0]), .neg(negRes), .res(quoFix));
  muldiv_sign_fix #(.W(XLEN)) uFixRem (.val(accReg[XLEN-1:0]), .neg(negRem), .res(remFix));

  // Divide by zero: the restoring loop already leaves |opA| as remainder; quotient is forced.
  always_comb begin
    if (isDivOp(opReg)) begin
      hiData = remFix;
      loData = divZero ? '1 : quoFix;
    end else begin
      hiData = prodFix[2*XLEN-1:XLEN];
      loData = prodFix[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      opReg         <= OP_MULTU;
      hiAddrReg     <= '0;
      loAddrReg     <= '0;
      accReg        <= '0;
      shiftReg      <= '0;
      opBReg        <= '0;
      cnt           <= '0;
      negRes        <= 1'b0;
      negRem        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      divZero       <= 1'b0;
      writeEnable1  <= 1'b0;
      writeAddress1 <= '0;
      writeData1    <= '0;
      writeEnable2  <= 1'b0;
      writeAddress2 <= '0;
      writeData2    <= '0;
    end else begin
      done         <= 1'b0;
      writeEnable1 <= 1'b0;
      writeEnable2 <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy is still high during the write-back cycle, which blocks a start there
          if (start && !busy) begin
            opReg     <= op;
            hiAddrReg <= hiAddr;
            loAddrReg <= loAddr;
            accReg    <= '0;
            shiftReg  <= {{XLEN{1'b0}}, absA};
            opBReg    <= absB;
            cnt       <= CW'(XLEN - 1);
            negRes    <= inSigned & (opA[XLEN-1] ^ opB[XLEN-1]);
            negRem    <= inSigned & opA[XLEN-1];
            divZero   <= isDivOp(op) && (opB == '0);
            busy      <= 1'b1;
            state     <= S_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (isDivOp(opReg)) begin
            accReg[XLEN-1:0]   <= remNext;
            shiftReg[XLEN-1:0] <= {shiftReg[XLEN-2:0], qBit};
          end else begin
            accReg   <= accMul;
            shiftReg <= shiftReg << 1;
            opBReg   <= opBReg >> 1;
          end
          if (lastIter) state <= S_WB;
          else          cnt   <= cnt - 1'b1;
        end
        S_WB: begin
          writeEnable1  <= (hiAddrReg != '0) && (hiAddrReg != loAddrReg);
          writeEnable2  <= (loAddrReg != '0);
          writeAddress1 <= hiAddrReg;
          writeAddress2 <= loAddrReg;
          writeData1    <= hiData;
          writeData2    <= loData;
          done          <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Directed bench for muldiv_wb_unit: hand-computed HI/LO results, latency, strobe counts, reset abort.
module tb_muldiv_wb_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opA = '0, opB = '0;
  logic [4:0]  hiAddr = '0, loAddr = '0;
  logic        busy, done, divZero;
  logic        writeEnable1, writeEnable2;
  logic [4:0]  writeAddress1, writeAddress2;
  logic [31:0] writeData1, writeData2;

  int total = 0;
  int bad = 0;

  logic [31:0] gotHi, gotLo;
  logic [4:0]  gotHiAddr, gotLoAddr;
  logic        gotDz;
  int          lat, we1Cnt, we2Cnt, doneCnt;

  always #5 clk = ~clk;

  muldiv_wb_unit #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .hiAddr(hiAddr), .loAddr(loAddr), .busy(busy), .done(done), .divZero(divZero),
    .writeEnable1(writeEnable1), .writeAddress1(writeAddress1), .writeData1(writeData1),
    .writeEnable2(writeEnable2), .writeAddress2(writeAddress2), .writeData2(writeData2)
  );

  // Issue one op and watch 60 cycles; cycle c is the negedge after acceptance edge N+c.
  // injAt>0 pulses a second, different start during that cycle.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ha, input logic [4:0] la, input int injAt);
    lat = -1; we1Cnt = 0; we2Cnt = 0; doneCnt = 0;
    gotHi = 'x; gotLo = 'x; gotHiAddr = 'x; gotLoAddr = 'x; gotDz = 1'bx;
    @(negedge clk);
    op = o; opA = a; opB = b; hiAddr = ha; loAddr = la; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == injAt) begin
        start = 1'b1; op = OP_MULTU; opA = 32'h0000_1234; opB = 32'h0000_5678;
        hiAddr = 5'd9; loAddr = 5'd10;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        if (doneCnt == 0) begin
          lat = c; gotHi = writeData1; gotLo = writeData2;
          gotHiAddr = writeAddress1; gotLoAddr = writeAddress2; gotDz = divZero;
        end
        doneCnt++;
      end
      if (writeEnable1) we1Cnt++;
      if (writeEnable2) we2Cnt++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, done, divZero, writeEnable1, writeEnable2} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {busy, done, divZero, writeEnable1, writeEnable2});
    end
    total++;
    if ({writeAddress1, writeAddress2, writeData1, writeData2} !== 74'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {writeAddress1, writeAddress2, writeData1, writeData2});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 5'd3, 0);
    total++;
    if (gotHi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", gotHi); end
    total++;
    if (gotLo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", gotLo); end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL multu_latency got=%0d want=33", lat); end
    total++;
    if (we1Cnt !== 1 || we2Cnt !== 1) begin
      bad++; $display("FAIL multu_strobes got=%0d/%0d want=1/1", we1Cnt, we2Cnt);
    end
    total++;
    if (gotHiAddr !== 5'd2 || gotLoAddr !== 5'd3) begin
      bad++; $display("FAIL multu_addr got=%0d/%0d want=2/3", gotHiAddr, gotLoAddr);
    end
  endtask

  task automatic test_signed();
    runOp(OP_MULT, 32'hFFFF_FFF9, 32'd3, 5'd4, 5'd5, 0);
    total++;
    if (gotHi !== 32'hFFFF_FFFF || gotLo !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mult_neg got=%h_%h want=ffffffff_ffffffeb", gotHi, gotLo);
    end
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 5'd5, 0);
    total++;
    if (gotLo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_quo got=%h want=fffffffd", gotLo); end
    total++;
    if (gotHi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_rem got=%h want=ffffffff", gotHi); end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", lat); end
  endtask

  task automatic test_div_zero();
    runOp(OP_DIVU, 32'd100, 32'd0, 5'd6, 5'd7, 0);
    total++;
    if (gotLo !== 32'hFFFF_FFFF || gotHi !== 32'd100) begin
      bad++; $display("FAIL divzero_result got=%h_%h want=00000064_ffffffff", gotHi, gotLo);
    end
    total++;
    if (gotDz !== 1'b1 || we2Cnt !== 1) begin
      bad++; $display("FAIL divzero_flag got=%b we2=%0d want=1 we2=1", gotDz, we2Cnt);
    end
    runOp(OP_MULTU, 32'd2, 32'd3, 5'd6, 5'd7, 0);
    total++;
    if (gotDz !== 1'b0 || gotLo !== 32'd6) begin
      bad++; $display("FAIL divzero_clear got=%b lo=%h want=0 lo=00000006", gotDz, gotLo);
    end
  endtask

  task automatic test_int_min_and_addr();
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 5'd5, 0);
    total++;
    if (gotLo !== 32'h8000_0000 || gotHi !== 32'd0) begin
      bad++; $display("FAIL int_min_div got=%h_%h want=00000000_80000000", gotHi, gotLo);
    end
    total++;
    if (we1Cnt !== 0 || we2Cnt !== 1) begin
      bad++; $display("FAIL same_addr got=%0d/%0d want=0/1", we1Cnt, we2Cnt);
    end
    runOp(OP_MULTU, 32'd5, 32'd5, 5'd0, 5'd8, 0);
    total++;
    if (we1Cnt !== 0 || we2Cnt !== 1 || gotLo !== 32'd25) begin
      bad++; $display("FAIL hi_addr_zero got=%0d/%0d lo=%h want=0/1 lo=00000019", we1Cnt, we2Cnt, gotLo);
    end
  endtask

  task automatic test_busy_start();
    // 1000/7 = 142 rem 6; the mid-run MULTU must be dropped
    runOp(OP_DIVU, 32'd1000, 32'd7, 5'd11, 5'd12, 10);
    total++;
    if (gotLo !== 32'd142 || gotHi !== 32'd6) begin
      bad++; $display("FAIL busy_start_result got=%h_%h want=00000006_0000008e", gotHi, gotLo);
    end
    total++;
    if (doneCnt !== 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", doneCnt); end
  endtask

  task automatic test_reset_mid();
    int strobes;
    @(negedge clk);
    op = OP_MULTU; opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; hiAddr = 5'd2; loAddr = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, writeEnable1, writeEnable2, writeData1, writeData2} !== 68'd0) begin
      bad++; $display("FAIL reset_mid got=%h want=0", {busy, done, writeEnable1, writeEnable2, writeData1, writeData2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (writeEnable1 || writeEnable2 || done) strobes++;
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL reset_abort got=%0d want=0", strobes); end
    runOp(OP_MULTU, 32'd6, 32'd7, 5'd1, 5'd2, 0);
    total++;
    if (gotLo !== 32'd42 || gotHi !== 32'd0) begin
      bad++; $display("FAIL post_reset_mul got=%h_%h want=00000000_0000002a", gotHi, gotLo);
    end
    total++;
`ifdef MULDIV_EARLY_OUT_EN
    if (lat < 1 || lat > 5) begin bad++; $display("FAIL early_out_latency got=%0d want<=5", lat); end
`else
    if (lat !== 33) begin bad++; $display("FAIL post_reset_latency got=%0d want=33", lat); end
`endif
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_zero();
    test_int_min_and_addr();
    test_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
